base_runner: RTL

Consumer end of the batting pulse interface. Receives the one-cycle hit pulses and out pulses from the batting controller, then keeps the game state: base occupancy, outs, half-inning, inning and both team scores. Its registered outputs drive the scoreboard/LED display logic.

---
 rtl/baseball_pkg.sv | 33 +++
 rtl/runner_advance.sv | 23 ++
 rtl/base_runner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/baseball_pkg.sv
// Shared definitions for the base runner: pulse and base bit positions,
// game-state encoding and the last playable inning.
package baseball_pkg;

   // hit_pulse is packed {hit1,hit2,hit3,hit4}, so hit1 is the MSB
   localparam int HIT1_BIT = 3;
   localparam int HIT2_BIT = 2;
   localparam int HIT3_BIT = 1;
   localparam int HIT4_BIT = 0;

   localparam int BASE_FIRST  = 0;
   localparam int BASE_SECOND = 1;
   localparam int BASE_THIRD  = 2;

   localparam logic [3:0] MAX_INNING = 4'd15;

   typedef enum logic [1:0] {
      ST_PLAY      = 2'd0,
      ST_CHANGE    = 2'd1,
      ST_GAME_OVER = 2'd2
   } state_e;

   function automatic logic [2:0] hit_to_k(input logic [3:0] hit);
      logic [2:0] k;
      k = 3'd0;
      if (hit[HIT1_BIT]) k = 3'd1;
      if (hit[HIT2_BIT]) k = 3'd2;
      if (hit[HIT3_BIT]) k = 3'd3;
      if (hit[HIT4_BIT]) k = 3'd4;
      return k;
   endfunction

endpackage

// File: rtl/runner_advance.sv
// Combinational runner advancement: batter joins the bases, everyone moves
// k bases, and whoever passes home is counted as a run.
import baseball_pkg::*;

module runner_advance (
   input  logic [2:0] bases_i,
   input  logic [2:0] k_i,
   output logic [2:0] new_bases_o,
   output logic [2:0] runs_o
);

   // sh holds bits [7:1] of {bases,batter} << k; bit 0 is always empty
   logic [6:0] sh;

   assign sh = 7'(({4'b0000, bases_i, 1'b1} << k_i) >> 1);

   assign new_bases_o[BASE_FIRST]  = sh[0];
   assign new_bases_o[BASE_SECOND] = sh[1];
   assign new_bases_o[BASE_THIRD]  = sh[2];

   assign runs_o = {2'b00, sh[3]} + {2'b00, sh[4]} + {2'b00, sh[5]} + {2'b00, sh[6]};

endmodule

// File: rtl/base_runner.sv
// Game-state keeper fed by batting hit/out pulses.
// Optional MERCY_RULE_EN ends the game late on a large run lead.
import baseball_pkg::*;

// state        | meaning
// ST_PLAY      | accepting hit/out pulses for the current half-inning
// ST_CHANGE    | side retired; timed pause before the next half-inning
// ST_GAME_OVER | final; everything frozen until reset_n or new_game
module base_runner #(
   parameter int INNINGS     = 9,
   parameter int SCORE_W     = 7,
   parameter int CHANGE_HOLD = 4,
   parameter int MERCY_LEAD  = 10
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               new_game_i,
   input  logic [3:0]         hit_pulse_i,
   input  logic               out_pulse_i,
   output logic [2:0]         bases_o,
   output logic [1:0]         outs_o,
   output logic               half_o,
   output logic [3:0]         inning_o,
   output logic [SCORE_W-1:0] score_top_o,
   output logic [SCORE_W-1:0] score_bot_o,
   output logic               run_pulse_o,
   output logic [2:0]         runs_play_o,
   output logic               changeover_o,
   output logic               game_over_o,
   output logic               proto_err_o
);

   localparam int                  HOLD_W    = (CHANGE_HOLD > 1) ? $clog2(CHANGE_HOLD) : 1;
   localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(CHANGE_HOLD - 1);
   localparam logic [3:0]          LAST_REG  = 4'(INNINGS);
   localparam logic [SCORE_W-1:0]  SCORE_MAX = '1;

   if (CHANGE_HOLD < 1 || MERCY_LEAD < 1) begin : g_param_check
      $error("base_runner: CHANGE_HOLD and MERCY_LEAD must be at least 1");
   end

   state_e             state_q, state_d;
   logic [2:0]         bases_q, bases_d;
   logic [1:0]         outs_q, outs_d;
   logic               half_q, half_d;
   logic [3:0]         inning_q, inning_d;
   logic [SCORE_W-1:0] score_top_q, score_top_d;
   logic [SCORE_W-1:0] score_bot_q, score_bot_d;
   logic               run_pulse_q, run_pulse_d;
   logic [2:0]         runs_play_q, runs_play_d;
   logic               proto_err_q, proto_err_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;

   logic               evt_multi;
   logic [2:0]         hit_k, adv_bases, adv_runs;
   logic [SCORE_W-1:0] top_hit, bot_hit;
   logic               half_ends_game;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [2:0]         r);
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + (SCORE_W+1)'(r);
      return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
   endfunction

   assign evt_multi = ($countones({hit_pulse_i, out_pulse_i}) > 1);
   assign hit_k     = hit_to_k(hit_pulse_i);
   assign top_hit   = sat_add(score_top_q, adv_runs);
   assign bot_hit   = sat_add(score_bot_q, adv_runs);

   runner_advance u_advance (
      .bases_i     (bases_q),
      .k_i         (hit_k),
      .new_bases_o (adv_bases),
      .runs_o      (adv_runs)
   );

`ifdef MERCY_RULE_EN
   localparam logic [3:0]         MERCY_FROM = 4'(INNINGS - 2);
   localparam logic [SCORE_W-1:0] MERCY_L    = SCORE_W'(MERCY_LEAD);
   logic [SCORE_W-1:0] lead;
   assign lead = (score_top_q > score_bot_q) ? score_top_q - score_bot_q
                                             : score_bot_q - score_top_q;
`endif

   // Decision taken at the third out; CHANGE itself always returns to PLAY
   always_comb begin
      half_ends_game = 1'b0;
      if (inning_q == MAX_INNING) begin
         half_ends_game = 1'b1;
      end else if (inning_q >= LAST_REG) begin
         if (!half_q && (score_bot_q > score_top_q)) half_ends_game = 1'b1;
         if (half_q && (score_bot_q != score_top_q)) half_ends_game = 1'b1;
      end
`ifdef MERCY_RULE_EN
      if ((inning_q >= MERCY_FROM) && (lead >= MERCY_L)) half_ends_game = 1'b1;
`endif
   end

   always_comb begin
      state_d     = state_q;
      bases_d     = bases_q;
      outs_d      = outs_q;
      half_d      = half_q;
      inning_d    = inning_q;
      score_top_d = score_top_q;
      score_bot_d = score_bot_q;
      run_pulse_d = 1'b0;
      runs_play_d = 3'd0;
      proto_err_d = proto_err_q;
      hold_d      = hold_q;
      case (state_q)
         ST_PLAY: begin
            if (evt_multi) begin
               proto_err_d = 1'b1;
            end else if (out_pulse_i) begin
               if (outs_q != 2'd2) begin
                  outs_d = outs_q + 2'd1;
               end else begin
                  outs_d = 2'd0;
                  if (half_ends_game) begin
                     state_d = ST_GAME_OVER;
                  end else begin
                     state_d = ST_CHANGE;
                     hold_d  = HOLD_LOAD;
                  end
               end
            end else if (hit_pulse_i != 4'd0) begin
               bases_d = adv_bases;
               if (adv_runs != 3'd0) begin
                  run_pulse_d = 1'b1;
                  runs_play_d = adv_runs;
               end
               if (half_q) begin
                  score_bot_d = bot_hit;
                  if ((inning_q >= LAST_REG) && (bot_hit > score_top_q)) state_d = ST_GAME_OVER;
               end else begin
                  score_top_d = top_hit;
               end
            end
         end
         ST_CHANGE: begin
            if (hold_q == '0) begin
               state_d = ST_PLAY;
               bases_d = 3'd0;
               half_d  = ~half_q;
               if (half_q) inning_d = inning_q + 4'd1;
            end else begin
               hold_d = hold_q - HOLD_W'(1);
            end
         end
         ST_GAME_OVER: begin
         end
         default: state_d = ST_PLAY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i || new_game_i) begin
         state_q     <= ST_PLAY;
         bases_q     <= 3'd0;
         outs_q      <= 2'd0;
         half_q      <= 1'b0;
         inning_q    <= 4'd1;
         score_top_q <= '0;
         score_bot_q <= '0;
         run_pulse_q <= 1'b0;
         runs_play_q <= 3'd0;
         proto_err_q <= 1'b0;
         hold_q      <= '0;
      end else begin
         state_q     <= state_d;
         bases_q     <= bases_d;
         outs_q      <= outs_d;
         half_q      <= half_d;
         inning_q    <= inning_d;
         score_top_q <= score_top_d;
         score_bot_q <= score_bot_d;
         run_pulse_q <= run_pulse_d;
         runs_play_q <= runs_play_d;
         proto_err_q <= proto_err_d;
         hold_q      <= hold_d;
      end
   end

   assign bases_o      = bases_q;
   assign outs_o       = outs_q;
   assign half_o       = half_q;
   assign inning_o     = inning_q;
   assign score_top_o  = score_top_q;
   assign score_bot_o  = score_bot_q;
   assign run_pulse_o  = run_pulse_q;
   assign runs_play_o  = runs_play_q;
   assign changeover_o = (state_q == ST_CHANGE);
   assign game_over_o  = (state_q == ST_GAME_OVER);
   assign proto_err_o  = proto_err_q;

endmodule
